// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit: tracks EX/MEM/WB destinations, registers EX operand selects, raises stall.
// Macro LAPIDO_FORWARD_EN enables forwarding with load-use stall; otherwise every EX/MEM dependency stalls.
module hazard_fwd_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  localparam stage_t     BUBBLE = '0;
  localparam logic [1:0] SEL_RF = 2'b00;

  stage_t           ex_q, ex_d, mem_q, wb_q;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_src, mem_src;
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic stall_raw, load_ex;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign ex_src  = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != 5'd0);
  assign mem_src = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0);

  assign rs_ex  = id_use_rs & ex_src  & (id_rs == ex_q.rd);
  assign rt_ex  = id_use_rt & ex_src  & (id_rt == ex_q.rd);
  assign rs_mem = id_use_rs & mem_src & (id_rs == mem_q.rd);
  assign rt_mem = id_use_rt & mem_src & (id_rt == mem_q.rd);

`ifdef LAPIDO_FORWARD_EN
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  function automatic logic [1:0] pick(input logic hit_ex, input logic hit_mem);
    pick = hit_ex ? SEL_EXMEM : (hit_mem ? SEL_MEMWB : SEL_RF);
  endfunction

  assign stall_raw = ex_q.mem_read & (rs_ex | rt_ex);
`else
  assign stall_raw = rs_ex | rt_ex | rs_mem | rt_mem;
`endif

  assign stall   = ~rst & id_valid & ~flush & stall_raw;
  assign load_ex = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d    = BUBBLE;
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    if (load_ex) begin
      ex_d = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
`ifdef LAPIDO_FORWARD_EN
      fwd_a_d = pick(rs_ex, rs_mem);
      fwd_b_d = pick(rt_ex, rt_mem);
`endif
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // WB needs no forwarding (regfile writes before read); a bubble there must carry no write intent.
  always @(posedge clk) begin
    if (!rst) begin
      assert (wb_q.valid || (wb_q == BUBBLE));
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: vector table plus reset-mid-stall and counter saturation sequences.
module tb_hazard_fwd_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct {
    ins_t       ins;
    logic       fl;
    logic       f_st;
    logic [1:0] f_a;
    logic [1:0] f_b;
    logic       n_st;
  } vec_t;

`ifdef LAPIDO_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam ins_t NOP = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, flush;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  fa, fb, fa4, fb4;
  logic        st, st4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;
  int model = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_fwd_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fa), .fwd_b_sel(fb), .stall(st), .stall_count(cnt)
  );

  hazard_fwd_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .fwd_a_sel(fa4), .fwd_b_sel(fb4), .stall(st4), .stall_count(cnt4)
  );

  function automatic ins_t alu(input int rd, input int rs, input int rt);
    alu = '{v: 1'b1, rs: 5'(rs), rt: 5'(rt), urs: 1'b1, urt: 1'b1,
            rd: 5'(rd), rw: 1'b1, mr: 1'b0};
  endfunction

  function automatic ins_t lw(input int rd, input int rs);
    lw = '{v: 1'b1, rs: 5'(rs), rt: 5'd0, urs: 1'b1, urt: 1'b0,
           rd: 5'(rd), rw: 1'b1, mr: 1'b1};
  endfunction

  function automatic int sat(input int c, input int m);
    sat = (c > m) ? m : c;
  endfunction

  task automatic add_row(input ins_t i, input logic fl, input logic fs,
                         input logic [1:0] fa_e, input logic [1:0] fb_e, input logic ns);
    vec_t r;
    r.ins = i; r.fl = fl; r.f_st = fs; r.f_a = fa_e; r.f_b = fb_e; r.n_st = ns;
    tbl.push_back(r);
  endtask

  task automatic drive(input ins_t i, input logic fl);
    id_valid     = i.v;
    id_rs        = i.rs;
    id_rt        = i.rt;
    id_use_rs    = i.urs;
    id_use_rt    = i.urt;
    id_rd        = i.rd;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    flush        = fl;
  endtask

  task automatic apply(input ins_t i, input logic fl);
    @(negedge clk);
    drive(i, fl);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    logic       exp_st;
    logic [1:0] exp_a, exp_b;
    ins_t       rt_only;

    rt_only = '{v: 1'b1, rs: 5'd3, rt: 5'd3, urs: 1'b0, urt: 1'b1, rd: 5'd7, rw: 1'b1, mr: 1'b0};

    // ins, flush, fwd{stall, a, b}, no-fwd stall
    add_row(alu(3,1,2), 0, 0, 2'd0, 2'd0, 0);   // A: back-to-back ALU dependency
    add_row(alu(4,3,5), 0, 0, 2'd1, 2'd0, 1);
    add_row(alu(4,3,5), 0, 0, 2'd2, 2'd0, 1);
    add_row(alu(4,3,5), 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(3,1,2), 0, 0, 2'd0, 2'd0, 0);   // B: distance-two dependency, then EX+MEM both r3
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(6,7,3), 0, 0, 2'd0, 2'd2, 1);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(3,1,2), 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(3,1,2), 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(6,7,3), 0, 0, 2'd0, 2'd1, 1);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(lw(2,1),    0, 0, 2'd0, 2'd0, 0);   // C: load-use
    add_row(alu(1,2,2), 0, 1, 2'd0, 2'd0, 1);
    add_row(alu(1,2,2), 0, 0, 2'd2, 2'd2, 1);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(lw(2,1),    0, 0, 2'd0, 2'd0, 0);   // D: load-use with flush, then r0 writers
    add_row(alu(1,2,2), 1, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(0,1,2), 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(4,0,0), 0, 0, 2'd0, 2'd0, 0);
    add_row(lw(0,1),    0, 0, 2'd0, 2'd0, 0);
    add_row(alu(5,0,0), 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(3,1,2), 0, 0, 2'd0, 2'd0, 0);   // E: flush kills a forwardable consumer
    add_row(alu(4,3,5), 1, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(alu(3,1,2), 0, 0, 2'd0, 2'd0, 0);   // F: rs matches but is not read
    add_row(rt_only,    0, 0, 2'd0, 2'd1, 1);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);
    add_row(NOP, 0, 0, 2'd0, 2'd0, 0);

    // Reset state, with a valid instruction presented in ID
    drive(alu(4,3,5), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",  32'(st),   32'd0);
    chk("rst_stall4", 32'(st4),  32'd0);
    chk("rst_fwd_a",  32'(fa),   32'd0);
    chk("rst_fwd_b",  32'(fb),   32'd0);
    chk("rst_cnt",    32'(cnt),  32'd0);
    chk("rst_cnt4",   32'(cnt4), 32'd0);
    apply(NOP, 1'b0);
    rst = 1'b0;
    @(posedge clk);

    foreach (tbl[k]) begin
      exp_st = FWD ? tbl[k].f_st : tbl[k].n_st;
      exp_a  = FWD ? tbl[k].f_a  : 2'b00;
      exp_b  = FWD ? tbl[k].f_b  : 2'b00;
      apply(tbl[k].ins, tbl[k].fl);
      #1;
      chk($sformatf("v%0d_stall", k),  32'(st),  32'(exp_st));
      chk($sformatf("v%0d_stall4", k), 32'(st4), 32'(exp_st));
      @(posedge clk);
      #1;
      if (exp_st) model++;
      chk($sformatf("v%0d_fwd_a", k),  32'(fa),   32'(exp_a));
      chk($sformatf("v%0d_fwd_b", k),  32'(fb),   32'(exp_b));
      chk($sformatf("v%0d_fwd_a4", k), 32'(fa4),  32'(exp_a));
      chk($sformatf("v%0d_cnt", k),    32'(cnt),  32'(sat(model, 65535)));
      chk($sformatf("v%0d_cnt4", k),   32'(cnt4), 32'(sat(model, 15)));
      $display("vec %0d: rs=%0d rt=%0d rd=%0d flush=%0d stall=%0d fa=%0d fb=%0d cnt=%0d",
               k, tbl[k].ins.rs, tbl[k].ins.rt, tbl[k].ins.rd, tbl[k].fl, exp_st, fa, fb, cnt);
    end

    // Reset asserted in the middle of a load-use stall
    apply(lw(2,1), 1'b0);
    @(posedge clk);
    #1;
    apply(alu(1,2,2), 1'b0);
    #1;
    chk("pre_rst_stall", 32'(st), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(st),   32'd0);
    chk("mid_rst_cnt",   32'(cnt),  32'd0);
    chk("mid_rst_cnt4",  32'(cnt4), 32'd0);
    chk("mid_rst_fwd_a", 32'(fa),   32'd0);
    chk("mid_rst_fwd_b", 32'(fb),   32'd0);
    $display("reset mid-stall: stall=%0d cnt=%0d", st, cnt);
    apply(alu(1,2,2), 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", 32'(st), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_fwd_a", 32'(fa),  32'd0);
    chk("post_rst_fwd_b", 32'(fb),  32'd0);
    chk("post_rst_cnt",   32'(cnt), 32'd0);
    $display("post-reset cycle: fa=%0d fb=%0d cnt=%0d", fa, fb, cnt);

    // Drive repeated load-use pairs to push the 4-bit counter past saturation
    for (int p = 0; p < 20; p++) begin
      apply(NOP, 1'b0);
      apply(NOP, 1'b0);
      apply(lw(2,1), 1'b0);
      apply(alu(1,2,2), 1'b0);
      apply(alu(1,2,2), 1'b0);
      @(posedge clk);
      #1;
      $display("pair %0d: cnt=%0d cnt4=%0d", p, cnt, cnt4);
      if (p == 15) begin
        chk("sat16_cnt",  32'(cnt),  FWD ? 32'd16 : 32'd32);
        chk("sat16_cnt4", 32'(cnt4), 32'd15);
      end
    end
    chk("sat20_cnt",  32'(cnt),  FWD ? 32'd20 : 32'd40);
    chk("sat20_cnt4", 32'(cnt4), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
